// File: rtl/reg_memory_elastic.sv
// MEM->WB pipeline register with valid/ready handshake, optional skid entry,
// flush, and a saturating back-pressure cycle counter.
module reg_memory_elastic #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int SKID       = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] ReadDataM,
   input  logic [DATA_WIDTH-1:0] PCPlus4M,
   input  logic [ADDR_WIDTH-1:0] RdM,
   input  logic                  RegWriteM,
   input  logic [1:0]            ResultSrcM,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [DATA_WIDTH-1:0] ALUResultW,
   output logic [DATA_WIDTH-1:0] ReadDataW,
   output logic [DATA_WIDTH-1:0] PCPlus4W,
   output logic [ADDR_WIDTH-1:0] RdW,
   output logic [1:0]            ResultSrcW,
   output logic                  RegWriteW,
   output logic [CNT_WIDTH-1:0]  stall_count
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] alu;
      logic [DATA_WIDTH-1:0] rdata;
      logic [DATA_WIDTH-1:0] pc4;
      logic [ADDR_WIDTH-1:0] rd;
      logic                  rw;
      logic [1:0]            rsrc;
   } entry_t;

   entry_t in_e;
   entry_t out_q;
   logic   out_v;
   logic   accept;
   logic   stalled;

   assign in_e = '{alu: ALUResultM, rdata: ReadDataM, pc4: PCPlus4M,
                   rd: RdM, rw: RegWriteM, rsrc: ResultSrcM};

   assign accept  = valid_in & ready_out;
   assign stalled = out_v & ~ready_in;

   generate
      if (SKID != 0) begin : g_skid
         entry_t skid_q;
         logic   skid_v;

         // ready_out is a flop output: no path from ready_in.
         assign ready_out = ~skid_v;

         always_ff @(posedge clk) begin
            if (rst) begin
               out_v  <= 1'b0;
               skid_v <= 1'b0;
               out_q  <= '0;
               skid_q <= '0;
            end else if (flush) begin
               out_v  <= 1'b0;
               skid_v <= 1'b0;
            end else if (!out_v || ready_in) begin
               if (skid_v) begin
                  out_q  <= skid_q;
                  out_v  <= 1'b1;
                  skid_v <= 1'b0;
               end else if (accept) begin
                  out_q <= in_e;
                  out_v <= 1'b1;
               end else begin
                  out_v <= 1'b0;
               end
            end else if (accept) begin
               skid_q <= in_e;
               skid_v <= 1'b1;
            end
         end
      end else begin : g_single
         assign ready_out = ready_in | ~out_v;

         always_ff @(posedge clk) begin
            if (rst) begin
               out_v <= 1'b0;
               out_q <= '0;
            end else if (flush) begin
               out_v <= 1'b0;
            end else if (accept) begin
               out_q <= in_e;
               out_v <= 1'b1;
            end else if (ready_in) begin
               out_v <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (stalled && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   assign valid_out  = out_v;
   assign ALUResultW = out_q.alu;
   assign ReadDataW  = out_q.rdata;
   assign PCPlus4W   = out_q.pc4;
   assign RdW        = out_q.rd;
   assign ResultSrcW = out_q.rsrc;
   assign RegWriteW  = out_v & out_q.rw & (out_q.rd != '0);

endmodule

// File: tb/tb_reg_memory_elastic.sv
// Bench for reg_memory_elastic: SKID=1 and SKID=0 instances on shared inputs,
// checked against per-instance queue models plus directed literal expectations.
module tb_reg_memory_elastic;

   logic        clk = 1'b0;
   logic        rst, flush, valid_in, ready_in;
   logic [31:0] alu_m, rdata_m, pc_m;
   logic [4:0]  rd_m;
   logic        rw_m;
   logic [1:0]  rs_m;

   logic        rdy1, v1, rw1;
   logic [31:0] alu1, rdat1, pc1;
   logic [4:0]  rd1;
   logic [1:0]  rs1;
   logic [3:0]  sc1;

   logic        rdy0, v0, rw0;
   logic [31:0] alu0, rdat0, pc0;
   logic [4:0]  rd0;
   logic [1:0]  rs0;
   logic [3:0]  sc0;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   always #5 clk = ~clk;

   reg_memory_elastic #(.SKID(1), .CNT_WIDTH(4)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
      .ready_out(rdy1), .ALUResultM(alu_m), .ReadDataM(rdata_m),
      .PCPlus4M(pc_m), .RdM(rd_m), .RegWriteM(rw_m), .ResultSrcM(rs_m),
      .valid_out(v1), .ready_in(ready_in), .ALUResultW(alu1),
      .ReadDataW(rdat1), .PCPlus4W(pc1), .RdW(rd1), .ResultSrcW(rs1),
      .RegWriteW(rw1), .stall_count(sc1));

   reg_memory_elastic #(.SKID(0), .CNT_WIDTH(4)) u0 (
      .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
      .ready_out(rdy0), .ALUResultM(alu_m), .ReadDataM(rdata_m),
      .PCPlus4M(pc_m), .RdM(rd_m), .RegWriteM(rw_m), .ResultSrcM(rs_m),
      .valid_out(v0), .ready_in(ready_in), .ALUResultW(alu0),
      .ReadDataW(rdat0), .PCPlus4W(pc0), .RdW(rd0), .ResultSrcW(rs0),
      .RegWriteW(rw0), .stall_count(sc0));

   typedef struct {
      logic [31:0] a, d, p;
      logic [4:0]  rd;
      logic        w;
      logic [1:0]  rs;
   } ent_t;

   ent_t q1[$];
   ent_t q0[$];
   int   m_sc1, m_sc0;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: a FIFO of capacity 2 (skid) or 1 (single), popped on consume.
   always @(posedge clk) begin
      ent_t e;
      bit   acc1, acc0, con1, con0;
      e = '{a: alu_m, d: rdata_m, p: pc_m, rd: rd_m, w: rw_m, rs: rs_m};
      if (rst) begin
         q1.delete();
         q0.delete();
         m_sc1 = 0;
         m_sc0 = 0;
      end else begin
         if (q1.size() > 0 && !ready_in && m_sc1 < 15) m_sc1++;
         if (q0.size() > 0 && !ready_in && m_sc0 < 15) m_sc0++;
         acc1 = valid_in && (q1.size() < 2);
         con1 = (q1.size() > 0) && ready_in;
         acc0 = valid_in && (ready_in || q0.size() == 0);
         con0 = (q0.size() > 0) && ready_in;
         if (flush) begin
            q1.delete();
            q0.delete();
         end else begin
            if (con1) void'(q1.pop_front());
            if (acc1) q1.push_back(e);
            if (con0) void'(q0.pop_front());
            if (acc0) q0.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("s1_valid", 32'(v1), 32'(q1.size() > 0));
         chk("s1_ready", 32'(rdy1), 32'(q1.size() < 2));
         chk("s1_stall", 32'(sc1), 32'(m_sc1));
         chk("s0_valid", 32'(v0), 32'(q0.size() > 0));
         chk("s0_ready", 32'(rdy0), 32'(ready_in || q0.size() == 0));
         chk("s0_stall", 32'(sc0), 32'(m_sc0));
         if (q1.size() > 0) begin
            chk("s1_alu", alu1, q1[0].a);
            chk("s1_rdata", rdat1, q1[0].d);
            chk("s1_pc", pc1, q1[0].p);
            chk("s1_rd", 32'(rd1), 32'(q1[0].rd));
            chk("s1_rs", 32'(rs1), 32'(q1[0].rs));
            chk("s1_rw", 32'(rw1), 32'(q1[0].w && q1[0].rd != 0));
         end else begin
            chk("s1_rw_idle", 32'(rw1), 32'd0);
         end
         if (q0.size() > 0) begin
            chk("s0_alu", alu0, q0[0].a);
            chk("s0_rdata", rdat0, q0[0].d);
            chk("s0_pc", pc0, q0[0].p);
            chk("s0_rd", 32'(rd0), 32'(q0[0].rd));
            chk("s0_rs", 32'(rs0), 32'(q0[0].rs));
            chk("s0_rw", 32'(rw0), 32'(q0[0].w && q0[0].rd != 0));
         end else begin
            chk("s0_rw_idle", 32'(rw0), 32'd0);
         end
      end
   end

   task automatic drive(bit r, bit f, bit v, bit rdy, logic [31:0] a,
                        logic [4:0] d = 5'd1, bit w = 1'b1,
                        logic [1:0] s = 2'd1);
      @(posedge clk);
      #1;
      rst      = r;
      flush    = f;
      valid_in = v;
      ready_in = rdy;
      alu_m    = a;
      rdata_m  = a ^ 32'hdead_beef;
      pc_m     = a + 32'd4;
      rd_m     = d;
      rw_m     = w;
      rs_m     = s;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      alu_m = '0; rdata_m = '0; pc_m = '0; rd_m = '0; rw_m = 1'b0;
      rs_m = '0;
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      armed = 1'b1;
      chk("rst_valid", 32'(v1), 32'd0);
      chk("rst_ready", 32'(rdy1), 32'd1);
      chk("rst_alu", alu1, 32'd0);
      chk("rst_stall", 32'(sc1), 32'd0);

      // stream 0x10..0x17 at full rate
      drive(0, 0, 1, 1, 32'h10);
      for (int i = 1; i <= 8; i++) begin
         drive(0, 0, i < 8, 1, 32'h10 + i);
         chk("stream_alu", alu1, 32'h10 + i - 1);
         chk("stream_valid", 32'(v1), 32'd1);
         chk("stream_ready", 32'(rdy1), 32'd1);
         chk("stream_s0_alu", alu0, 32'h10 + i - 1);
      end
      drive(0, 0, 0, 1, 0);
      chk("stream_drain", 32'(v1), 32'd0);

      // A held, B in skid, then release
      drive(0, 0, 1, 0, 32'hA);
      drive(0, 0, 1, 0, 32'hB);
      drive(0, 0, 0, 0, 0);
      chk("skid_A_held", alu1, 32'hA);
      chk("skid_full", 32'(rdy1), 32'd0);
      drive(0, 0, 0, 1, 0);
      chk("skid_A_still", alu1, 32'hA);
      drive(0, 0, 0, 1, 0);
      chk("skid_B_out", alu1, 32'hB);
      chk("skid_B_ready", 32'(rdy1), 32'd1);
      drive(0, 0, 0, 1, 0);
      chk("skid_empty", 32'(v1), 32'd0);

      // flush with output and skid full plus valid_in
      drive(0, 0, 1, 0, 32'hC);
      drive(0, 0, 1, 0, 32'hD);
      drive(0, 1, 1, 0, 32'hE);
      chk("pre_flush_ready", 32'(rdy1), 32'd0);
      drive(0, 0, 1, 1, 32'h55);
      chk("flush_valid", 32'(v1), 32'd0);
      chk("flush_ready", 32'(rdy1), 32'd1);
      drive(0, 0, 0, 1, 0);
      chk("post_flush_alu", alu1, 32'h55);
      chk("post_flush_valid", 32'(v1), 32'd1);

      // RegWriteW gating on Rd and valid
      drive(0, 0, 1, 1, 32'h60, 5'd0, 1'b1);
      drive(0, 0, 1, 1, 32'h61, 5'd5, 1'b1);
      chk("rw_rd0", 32'(rw1), 32'd0);
      drive(0, 0, 0, 1, 0);
      chk("rw_rd5", 32'(rw1), 32'd1);
      drive(0, 0, 0, 1, 0);
      chk("rw_idle", 32'(rw1), 32'd0);

      // stall counter saturation, then reset with an entry held
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 1, 0, 32'h77);
      repeat (21) drive(0, 0, 0, 0, 0);
      chk("stall_sat", 32'(sc1), 32'd15);
      chk("stall_sat_s0", 32'(sc0), 32'd15);
      drive(1, 0, 1, 0, 32'h99);
      drive(0, 0, 0, 1, 0);
      chk("rst2_valid", 32'(v1), 32'd0);
      chk("rst2_alu", alu1, 32'd0);
      chk("rst2_stall", 32'(sc1), 32'd0);
      chk("rst2_rw", 32'(rw1), 32'd0);
      chk("rst2_ready", 32'(rdy1), 32'd1);

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
               $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
